// File: rtl/avalon_mem_master_if.sv
// Word-wide Avalon-style memory bus between a load/store initiator and a memory slave.
interface avalon_mem_master_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avalon_mem_master.sv
// CPU load/store initiator: one byte/half/word access at a time on the Avalon-style bus,
// with lane steering, stall handling, optional stall timeout and extended load data.
module avalon_mem_master #(
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  avalon_mem_master_if.master bus
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW:0] TO_LIM  = (TW + 1)'(TIMEOUT);
  localparam logic [2:0]  LAT_LIM = 3'(READ_LATENCY);

  typedef enum logic [1:0] {IDLE, BUS, RDWAIT, RESP} state_t;

  state_t      state_q;
  logic        req_ready_q, resp_valid_q, resp_error_q;
  logic [31:0] resp_rdata_q;
  logic        read_q, write_q;
  logic [31:0] address_q, writedata_q;
  logic [3:0]  byteenable_q;
  logic [1:0]  size_q, ofs_q;
  logic        sgn_q, wr_q;
  logic [TW-1:0] stall_q;
  logic [2:0]  lat_q;

  logic [3:0]  be_d;
  logic [31:0] wd_d;
  logic        bad_d;

  // Align the addressed lanes down to bit 0, then zero- or sign-extend.
  function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [1:0] ofs,
                                              input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = rd >> {ofs, 3'b000};
    case (size)
      2'b00:   load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  always_comb begin
    be_d  = 4'b0000;
    wd_d  = req_wdata;
    bad_d = 1'b0;
    case (req_size)
      2'b00: begin
        be_d = 4'b0001 << req_addr[1:0];
        wd_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d  = 4'b0011 << req_addr[1:0];
        wd_d  = {2{req_wdata[15:0]}};
        bad_d = req_addr[0];
      end
      2'b10: begin
        be_d  = 4'b1111;
        bad_d = (req_addr[1:0] != 2'b00);
      end
      default: bad_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      size_q       <= '0;
      ofs_q        <= '0;
      sgn_q        <= 1'b0;
      wr_q         <= 1'b0;
      stall_q      <= '0;
      lat_q        <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            size_q      <= req_size;
            ofs_q       <= req_addr[1:0];
            sgn_q       <= req_signed;
            wr_q        <= req_write;
            stall_q     <= '0;
            if (bad_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q      <= BUS;
              address_q    <= {req_addr[31:2], 2'b00};
              byteenable_q <= be_d;
              writedata_q  <= req_write ? wd_d : 32'd0;
              read_q       <= ~req_write;
              write_q      <= req_write;
            end
          end
        end
        BUS: begin
          if (!bus.waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            if (wr_q) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b0;
              resp_rdata_q <= '0;
            end else begin
              state_q <= RDWAIT;
              lat_q   <= 3'd1;
            end
          end else if (TIMEOUT != 0 && ({1'b0, stall_q} + 1'b1) == TO_LIM) begin
            // Slave never released the stall: abandon the access.
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
        end
        RDWAIT: begin
          if (lat_q == LAT_LIM) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_rdata_q <= load_extend(bus.readdata, ofs_q, size_q, sgn_q);
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_error_q <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_error     = resp_error_q;
  assign resp_rdata     = resp_rdata_q;
  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.byteenable = byteenable_q;
  assign bus.writedata  = writedata_q;

endmodule
